// File: rtl/csa_accum_ctrl_pkg.sv
// rtl/csa_accum_ctrl_pkg.sv - shared types, defaults and helpers for the csa accumulator controller
package csa_ctrl_pkg;

  localparam int LANES_DEF  = 8;
  localparam int SIZE_I_DEF = 32;
  localparam int SIZE_O_DEF = 64;
  localparam int CNT_W_DEF  = 16;
  localparam int TREE_DEPTH = LANES_DEF + 2;
  localparam int ZX_W       = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    OUTPUT  = 2'd3
  } state_e;

  // Keeps only the low w_i bits; callers cast down to SIZE_O (SIZE_O <= ZX_W).
  function automatic logic [ZX_W-1:0] zext(input logic [ZX_W-1:0] x, input int unsigned w_i);
    logic [ZX_W-1:0] m;
    m = {ZX_W{1'b1}} >> (ZX_W - w_i);
    return x & m;
  endfunction

endpackage

// File: rtl/csa_accum_ctrl_if.sv
// rtl/csa_accum_ctrl_if.sv - control, beat and result bus; in_mask exists only with CSA_ACCUM_MASK_EN
interface csa_accum_ctrl_if #(
  parameter int SIZE_I = 32,
  parameter int LANES  = 8,
  parameter int SIZE_O = 64,
  parameter int CNT_W  = 16
);

  logic              start;
  logic [CNT_W-1:0]  cfg_beats;
  logic              in_valid;
  logic              in_ready;
  logic [SIZE_I-1:0] in_data [LANES-1:0];
`ifdef CSA_ACCUM_MASK_EN
  logic [LANES-1:0]  in_mask;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [SIZE_O-1:0] out_data;
  logic              busy;

  modport master (
    output start, cfg_beats, in_valid, in_data, out_ready,
`ifdef CSA_ACCUM_MASK_EN
    output in_mask,
`endif
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  start, cfg_beats, in_valid, in_data, out_ready,
`ifdef CSA_ACCUM_MASK_EN
    input  in_mask,
`endif
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/csa_tree.sv
// rtl/csa_tree.sv - combinational carry-save reduction of DEPTH operands to a sum/carry pair
module csa_tree #(
  parameter int SIZE_I = 32,
  parameter int DEPTH  = 10,
  parameter int SIZE_O = 64
) (
  input  logic [SIZE_I-1:0] a [DEPTH],
  output logic [SIZE_O-1:0] b [2]
);

  logic [SIZE_O-1:0] s;
  logic [SIZE_O-1:0] c;
  logic [SIZE_O-1:0] x;
  logic [SIZE_O-1:0] maj;

  // Carry comes out already shifted into its weight position.
  always_comb begin
    s   = '0;
    c   = '0;
    x   = '0;
    maj = '0;
    for (int i = 0; i < DEPTH; i++) begin
      x   = SIZE_O'(a[i]);
      maj = (s & c) | (s & x) | (c & x);
      s   = s ^ c ^ x;
      c   = maj << 1;
    end
    b[0] = s;
    b[1] = c;
  end

endmodule

// File: rtl/csa_accum_ctrl.sv
// rtl/csa_accum_ctrl.sv - multi-beat carry-save accumulator sequencer; optional lane mask via CSA_ACCUM_MASK_EN
module csa_accum_ctrl
  import csa_ctrl_pkg::*;
#(
  parameter int SIZE_I = SIZE_I_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int SIZE_O = SIZE_O_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic              clk,
  input logic              reset,
  csa_accum_ctrl_if.slave  bus
);

  localparam int DEPTH = LANES + 2;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cfg_q, cfg_d;
  logic [SIZE_O-1:0] sum_q, sum_d;
  logic [SIZE_O-1:0] carry_q, carry_d;
  logic [SIZE_O-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;

  logic [SIZE_O-1:0] tree_in  [DEPTH];
  logic [SIZE_O-1:0] tree_out [2];
  logic [LANES-1:0]  lane_en;
  logic              xfer;

`ifdef CSA_ACCUM_MASK_EN
  assign lane_en = bus.in_mask;
`else
  assign lane_en = '1;
`endif

  assign xfer = bus.in_valid && in_ready_q;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      tree_in[i] = lane_en[i] ? SIZE_O'(zext(ZX_W'(bus.in_data[i]), SIZE_I)) : '0;
    end
    tree_in[LANES]   = sum_q;
    tree_in[LANES+1] = carry_q;
  end

  csa_tree #(
    .SIZE_I (SIZE_O),
    .DEPTH  (DEPTH),
    .SIZE_O (SIZE_O)
  ) u_tree (
    .a (tree_in),
    .b (tree_out)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cfg_d       = cfg_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cfg_d   = bus.cfg_beats;
          cnt_d   = '0;
          sum_d   = '0;
          carry_d = '0;
          state_d = (bus.cfg_beats == '0) ? RESOLVE : ACCUM;
        end
      end
      ACCUM: begin
        if (xfer) begin
          sum_d   = tree_out[0];
          carry_d = tree_out[1];
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_d == cfg_q) state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        out_data_d  = sum_q + carry_q;
        out_valid_d = 1'b1;
        state_d     = OUTPUT;
      end
      OUTPUT: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flags follow the next state so they line up with state_q after the edge.
    in_ready_d = (state_d == ACCUM);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cfg_q       <= '0;
      sum_q       <= '0;
      carry_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cfg_q       <= cfg_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// tb/tb_csa_accum_ctrl.sv - directed vector bench for csa_accum_ctrl; mask case under CSA_ACCUM_MASK_EN
module tb_csa_accum_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   saw_ready;

  always #5 clk = ~clk;

  csa_accum_ctrl_if #(.SIZE_I(32), .LANES(8), .SIZE_O(64), .CNT_W(16)) ifc ();
  csa_accum_ctrl_if #(.SIZE_I(32), .LANES(8), .SIZE_O(34), .CNT_W(16)) ifc34 ();

  csa_accum_ctrl #(.SIZE_I(32), .LANES(8), .SIZE_O(64), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  csa_accum_ctrl #(.SIZE_I(32), .LANES(8), .SIZE_O(34), .CNT_W(16)) dut34 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc34)
  );

  typedef struct packed {
    logic [15:0]      cfg;
    logic [2:0][31:0] val;
    logic [2:0]       ramp;
    logic [7:0]       gap;
    logic [63:0]      exp;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_lanes(input logic [31:0] v, input bit ramp);
    for (int i = 0; i < 8; i++) ifc.in_data[i] = ramp ? v * 32'(i + 1) : v;
  endtask

  task automatic wait_out();
    for (int k = 0; k < 50; k++) begin
      if (ifc.out_valid) return;
      saw_ready |= ifc.in_ready;
      step();
    end
    chk("out_valid_timeout", {63'd0, ifc.out_valid}, 64'd1);
  endtask

  task automatic send_beat(input logic [31:0] v, input bit ramp, output int xfer_cyc);
    set_lanes(v, ramp);
    ifc.in_valid = 1'b1;
    for (int k = 0; k < 20 && !ifc.in_ready; k++) step();
    if (!ifc.in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
    xfer_cyc = cyc;
    step();
    ifc.in_valid = 1'b0;
  endtask

  task automatic start_acc(input logic [15:0] cfg, output int start_cyc);
    ifc.cfg_beats = cfg;
    ifc.start     = 1'b1;
    start_cyc     = cyc;
    step();
    ifc.start     = 1'b0;
  endtask

  task automatic run_vec(input vec_t vv, input string nm);
    int start_cyc;
    int xfer_cyc;
    ifc.out_ready = 1'b1;
    saw_ready     = 1'b0;
    xfer_cyc      = 0;
    start_acc(vv.cfg, start_cyc);
    for (int b = 0; b < int'(vv.cfg); b++) begin
      if (b > 0) begin
        for (int g = 0; g < int'(vv.gap); g++) begin
          chk({nm, "_gap_in_ready"}, {63'd0, ifc.in_ready}, 64'd1);
          step();
        end
      end
      send_beat(vv.val[b], vv.ramp[b], xfer_cyc);
    end
    wait_out();
    chk({nm, "_latency"}, 64'(cyc - ((vv.cfg == 0) ? start_cyc : xfer_cyc)), 64'd2);
    chk({nm, "_data"}, ifc.out_data, vv.exp);
    if (vv.cfg == 0) chk({nm, "_in_ready_seen"}, {63'd0, saw_ready}, 64'd0);
    step();
    chk({nm, "_valid_drop"}, {63'd0, ifc.out_valid}, 64'd0);
    chk({nm, "_busy_drop"}, {63'd0, ifc.busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   sc;
    int   xc;
    vec_t v_post;

    vecs[0] = '{cfg: 16'd1, val: {32'd0, 32'd0, 32'd1}, ramp: 3'b000, gap: 8'd0, exp: 64'd8};
    vecs[1] = '{cfg: 16'd3, val: {32'hFFFF_FFFF, 32'd10, 32'd1}, ramp: 3'b011, gap: 8'd2,
                exp: 64'h8_0000_0184};
    vecs[2] = '{cfg: 16'd0, val: '0, ramp: 3'b000, gap: 8'd0, exp: 64'd0};
    vecs[3] = '{cfg: 16'd2, val: {32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, ramp: 3'b000, gap: 8'd0,
                exp: 64'hF_FFFF_FFF0};
    vecs[4] = '{cfg: 16'd2, val: {32'd0, 32'd7, 32'd3}, ramp: 3'b011, gap: 8'd0, exp: 64'd360};
    v_post  = '{cfg: 16'd1, val: {32'd0, 32'd0, 32'd2}, ramp: 3'b000, gap: 8'd0, exp: 64'd16};

    ifc.start = 1'b0;
    ifc.cfg_beats = '0;
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b0;
    set_lanes(32'd0, 1'b0);
    ifc34.start = 1'b0;
    ifc34.cfg_beats = '0;
    ifc34.in_valid = 1'b0;
    ifc34.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) ifc34.in_data[i] = 32'd0;
`ifdef CSA_ACCUM_MASK_EN
    ifc.in_mask = '1;
    ifc34.in_mask = '1;
`endif

    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    step();
    chk("rst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, ifc.in_ready}, 64'd0);
    chk("rst_busy", {63'd0, ifc.busy}, 64'd0);
    chk("rst_out_data", ifc.out_data, 64'd0);

    for (int v = 0; v < 5; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // Result held under backpressure; start during OUTPUT and in the handshake cycle is ignored.
    ifc.out_ready = 1'b0;
    start_acc(16'd1, sc);
    send_beat(32'd2, 1'b0, xc);
    wait_out();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        ifc.start = 1'b1;
        ifc.cfg_beats = 16'd5;
      end
      chk("hold_valid", {63'd0, ifc.out_valid}, 64'd1);
      chk("hold_data", ifc.out_data, 64'd16);
      chk("hold_busy", {63'd0, ifc.busy}, 64'd1);
      step();
      ifc.start = 1'b0;
    end
    ifc.out_ready = 1'b1;
    ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
    chk("hold_release_busy", {63'd0, ifc.busy}, 64'd0);
    chk("hold_release_valid", {63'd0, ifc.out_valid}, 64'd0);
    step();
    chk("hs_start_ignored", {63'd0, ifc.in_ready}, 64'd0);

    // Asynchronous reset in the middle of a 4-beat accumulation.
    start_acc(16'd4, sc);
    send_beat(32'd1, 1'b0, xc);
    send_beat(32'd1, 1'b0, xc);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", {63'd0, ifc.busy}, 64'd0);
    chk("arst_in_ready", {63'd0, ifc.in_ready}, 64'd0);
    chk("arst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    chk("arst_out_data", ifc.out_data, 64'd0);
    @(negedge clk) reset = 1'b0;
    step();
    run_vec(v_post, "post_rst");

    // 34-bit accumulator wraps modulo 2^34.
    ifc34.out_ready = 1'b1;
    ifc34.cfg_beats = 16'd2;
    ifc34.start = 1'b1;
    step();
    ifc34.start = 1'b0;
    for (int i = 0; i < 8; i++) ifc34.in_data[i] = 32'hFFFF_FFFF;
    ifc34.in_valid = 1'b1;
    step();
    step();
    ifc34.in_valid = 1'b0;
    for (int k = 0; k < 20 && !ifc34.out_valid; k++) step();
    chk("wrap34_valid", {63'd0, ifc34.out_valid}, 64'd1);
    chk("wrap34_data", 64'(ifc34.out_data), 64'h3_FFFF_FFF0);
    step();

`ifdef CSA_ACCUM_MASK_EN
    ifc.in_mask = 8'b0000_1111;
    run_vec('{cfg: 16'd1, val: {32'd0, 32'd0, 32'd5}, ramp: 3'b000, gap: 8'd0, exp: 64'd20}, "mask");
    ifc.in_mask = '1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
